// File: rtl/pptree_pkg.sv
// Shared types and elaboration helpers for the pipelined prefix-tree ALU.
//   op_e              : operation encodings (2'b11 decodes as ADD in the datapath)
//   gp_t              : one bit's (generate, propagate) pair
//   levels_for()      : number of Kogge-Stone levels for a given width
//   stage_after_level : prefix level after which pipeline register k sits
//   reg_after_level   : 1 if some non-output register sits after the given level
package pptree_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SBC = 2'b10
  } op_e;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int levels_for(input int width);
    return $clog2(width);
  endfunction

  // Level 0 is operand prep; LEVELS+1 stands for "after sum/flags", the
  // output register.
  function automatic int stage_after_level(input int k, input int levels,
                                           input int stages);
    int lvl;
    if (k >= stages)  lvl = levels + 1;
    else if (k == 1)  lvl = 0;
    else              lvl = ((k - 1) * levels) / (stages - 1);
    return lvl;
  endfunction

  function automatic bit reg_after_level(input int lvl, input int levels,
                                         input int stages);
    bit hit;
    hit = 1'b0;
    for (int k = 1; k < stages; k++) begin
      if (stage_after_level(k, levels, stages) == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/pptree_pipe_alu_if.sv
// Operand/result bus of pptree_pipe_alu.
//   master : drives in_valid, op, a, b, cin, out_ready (and sat when enabled)
//   slave  : the ALU; drives in_ready, out_valid, sum, cout, ovf, zero
// Optional macro PPTREE_PIPE_ALU_SAT_EN adds the 1-bit sat request.
interface pptree_pipe_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
`ifdef PPTREE_PIPE_ALU_SAT_EN
  logic             sat;

  modport master (output in_valid, op, a, b, cin, sat, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero);
  modport slave  (input  in_valid, op, a, b, cin, sat, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero);
`else
  modport master (output in_valid, op, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero);
  modport slave  (input  in_valid, op, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero);
`endif
endinterface

// File: rtl/pptree_level.sv
// One combinational Kogge-Stone level: every bit at or above SPAN merges
// with the group SPAN positions below it; lower bits pass through.
//   gp_i : (G,P) groups entering the level
//   gp_o : (G,P) groups leaving the level
module pptree_level
  import pptree_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_merge
      assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i-SPAN].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[i-SPAN].p;
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end

endmodule

// File: rtl/pptree_pipe_alu.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready handshake and flags.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : pptree_pipe_alu_if slave (operands in, result + cout/ovf/zero out)
// PIPE_STAGES registers: one after operand prep, the rest spread evenly over
// the prefix levels, the last one holding the outputs. A single stall signal
// freezes every stage while a result waits for out_ready.
// Optional macro PPTREE_PIPE_ALU_SAT_EN adds bus.sat: clamp on signed overflow.
module pptree_pipe_alu
  import pptree_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pptree_pipe_alu_if.slave bus
);

  localparam int LEVELS = levels_for(WIDTH);

  // Operand-side data that rides alongside the (G,P) tree.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             cin;
    logic             a_msb;
    logic             sat;
  } side_t;

  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] s,
                                                 input logic ovf,
                                                 input logic sat,
                                                 input logic neg);
    logic [WIDTH-1:0] r;
    r = s;
    if (sat && ovf) r = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  logic advance;
  logic out_vld_q;

  assign advance      = !out_vld_q | bus.out_ready;
  assign bus.in_ready = advance;

  // ---- operand prep: invert b for SUB/SBC, fold carry-in into bit 0 ----
  logic [WIDTH-1:0] bb;
  logic             cin_eff;
  logic             sat_in;
  gp_t [WIDTH-1:0]  gp_prep;
  side_t            side_prep;

`ifdef PPTREE_PIPE_ALU_SAT_EN
  assign sat_in = bus.sat;
`else
  assign sat_in = 1'b0;
`endif

  always_comb begin
    bb      = (bus.op == OP_SUB || bus.op == OP_SBC) ? ~bus.b : bus.b;
    cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
    for (int i = 0; i < WIDTH; i++) begin
      gp_prep[i].g = bus.a[i] & bb[i];
      gp_prep[i].p = bus.a[i] ^ bb[i];
    end
    gp_prep[0].g    = gp_prep[0].g | (gp_prep[0].p & cin_eff);
    side_prep.p     = bus.a ^ bb;
    side_prep.cin   = cin_eff;
    side_prep.a_msb = bus.a[WIDTH-1];
    side_prep.sat   = sat_in;
  end

  // gp_s/side_s/vld_s[l]: values after level l and its optional register.
  gp_t [WIDTH-1:0] gp_s   [LEVELS+1];
  side_t           side_s [LEVELS+1];
  logic            vld_s  [LEVELS+1];

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    gp_t [WIDTH-1:0] gp_d;
    side_t           side_d;
    logic            vld_d;

    if (l == 0) begin : g_prep
      assign gp_d   = gp_prep;
      assign side_d = side_prep;
      assign vld_d  = bus.in_valid;
    end else begin : g_tree
      pptree_level #(.WIDTH(WIDTH), .SPAN(1 << (l - 1))) u_level (
        .gp_i (gp_s[l-1]),
        .gp_o (gp_d)
      );
      assign side_d = side_s[l-1];
      assign vld_d  = vld_s[l-1];
    end

    // ---- optional pipeline register after level l ----
    if (reg_after_level(l, LEVELS, PIPE_STAGES)) begin : g_reg
      gp_t [WIDTH-1:0] gp_q;
      side_t           side_q;
      logic            vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_q <= 1'b0;
        else if (advance) vld_q <= vld_d;
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          gp_q   <= gp_d;
          side_q <= side_d;
        end
      end

      assign gp_s[l]   = gp_q;
      assign side_s[l] = side_q;
      assign vld_s[l]  = vld_q;
    end else begin : g_wire
      assign gp_s[l]   = gp_d;
      assign side_s[l] = side_d;
      assign vld_s[l]  = vld_d;
    end
  end

  // ---- sum and flags; G of the final level is the carry out of each bit ----
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] prop_unused;
  logic [WIDTH-1:0] sum_wrap, sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry[i]       = gp_s[LEVELS][i].g;
      prop_unused[i] = gp_s[LEVELS][i].p;
    end
    sum_wrap = side_s[LEVELS].p ^ {carry[WIDTH-2:0], side_s[LEVELS].cin};
    cout_d   = carry[WIDTH-1];
    ovf_d    = carry[WIDTH-1] ^ carry[WIDTH-2];
    sum_d    = sat_clamp(sum_wrap, ovf_d, side_s[LEVELS].sat, side_s[LEVELS].a_msb);
    zero_d   = (sum_d == '0);
  end

  // ---- output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (advance) begin
      out_vld_q <= vld_s[LEVELS];
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pptree_pipe_alu.sv
// Directed bench for pptree_pipe_alu (WIDTH=8): main instance with
// PIPE_STAGES=2 plus PIPE_STAGES=1/3/4 instances for the depth sweep.
module tb_pptree_pipe_alu;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pptree_pipe_alu_if #(.WIDTH(W)) bus ();
  pptree_pipe_alu_if #(.WIDTH(W)) sw1 ();
  pptree_pipe_alu_if #(.WIDTH(W)) sw3 ();
  pptree_pipe_alu_if #(.WIDTH(W)) sw4 ();

  pptree_pipe_alu #(.WIDTH(W), .PIPE_STAGES(2)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
  pptree_pipe_alu #(.WIDTH(W), .PIPE_STAGES(1)) u_ps1  (.clk(clk), .rst_n(rst_n), .bus(sw1));
  pptree_pipe_alu #(.WIDTH(W), .PIPE_STAGES(3)) u_ps3  (.clk(clk), .rst_n(rst_n), .bus(sw3));
  pptree_pipe_alu #(.WIDTH(W), .PIPE_STAGES(4)) u_ps4  (.clk(clk), .rst_n(rst_n), .bus(sw4));

  // Behavioural reference: returns {zero, ovf, cout, sum}.
  function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [7:0] bb;
    logic       ci;
    logic [8:0] full;
    logic       ov;
    bb   = (op == 2'b01 || op == 2'b10) ? ~b : b;
    ci   = (op == 2'b01) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
    ov   = (a[7] == bb[7]) && (full[7] != a[7]);
    return {(full[7:0] == 8'd0), ov, full[8], full[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sweep(input logic v, input logic [1:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic cin);
    sw1.in_valid = v; sw1.op = op; sw1.a = a; sw1.b = b; sw1.cin = cin;
    sw3.in_valid = v; sw3.op = op; sw3.a = a; sw3.b = b; sw3.cin = cin;
    sw4.in_valid = v; sw4.op = op; sw4.a = a; sw4.b = b; sw4.cin = cin;
  endtask

  // One beat through the PIPE_STAGES=2 instance; returns with the result
  // sitting on the outputs.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sum=%h c=%b v=%b z=%b, want all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  t_op  [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [7:0]  t_a   [7] = '{8'hFF, 8'h80, 8'h00, 8'h10, 8'h7F, 8'h05, 8'h03};
    logic [7:0]  t_b   [7] = '{8'h01, 8'h01, 8'h00, 8'h20, 8'h01, 8'h03, 8'h05};
    logic        t_cin [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // {out_valid, cout, ovf, zero, sum}
    logic [11:0] t_exp [7] = '{{1'b1, 1'b1, 1'b0, 1'b1, 8'h00},
                              {1'b1, 1'b1, 1'b1, 1'b0, 8'h7F},
                              {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF},
                              {1'b1, 1'b0, 1'b0, 1'b0, 8'h31},
                              {1'b1, 1'b0, 1'b1, 1'b0, 8'h80},
                              {1'b1, 1'b1, 1'b0, 1'b0, 8'h02},
                              {1'b1, 1'b0, 1'b0, 1'b0, 8'hFE}};
    logic [11:0] got;
`ifdef PPTREE_PIPE_ALU_SAT_EN
    bus.sat = 1'b0;
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_cin[i]);
      got = {bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum};
      n_checks++;
      if (got !== t_exp[i]) begin
        n_fail++;
        $display("FAIL arith[%0d]: got {v,c,o,z,sum}=%h, want %h", i, got, t_exp[i]);
      end
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arith_drain: got out_valid=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    bit acc;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 5) begin
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.cin = 1'b0;
        bus.a = 8'(sent + 1); bus.b = 8'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready cyc %0d: got %b, want 0", cyc, bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'd4) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d: got valid=%b sum=%0d, want 1/4",
                   cyc, bus.out_valid, bus.sum);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_checks++;
        if (bus.sum !== 8'(2 * (got + 1))) begin
          n_fail++;
          $display("FAIL stream_result #%0d: got %0d, want %0d", got, bus.sum, 2 * (got + 1));
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    n_checks++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, want 5", got);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    tick();
    bus.a = 8'h02; bus.b = 8'h02;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'h02) begin
      n_fail++;
      $display("FAIL midflight_loaded: got valid=%b sum=%h, want 1/02", bus.out_valid, bus.sum);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'h00) begin
      n_fail++;
      $display("FAIL midflight_async: got valid=%b sum=%h, want 0/00", bus.out_valid, bus.sum);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_ghost cyc %0d: got out_valid=%b, want 0", i, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1; bus.a = 8'h07; bus.b = 8'h08;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_latency: got out_valid=%b one edge after accept, want 0",
               bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'h0F) begin
      n_fail++;
      $display("FAIL midflight_new: got valid=%b sum=%h, want 1/0F", bus.out_valid, bus.sum);
    end
    tick();
  endtask

  task automatic test_depth_sweep();
    localparam int N = 16;
    logic [10:0] exp_r [N];
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic        cin;
    int          idx;
    sw1.out_ready = 1'b1; sw3.out_ready = 1'b1; sw4.out_ready = 1'b1;
    for (int c = 0; c <= N + 4; c++) begin
      if (c < N) begin
        case (c)
          0:       begin op = 2'b00; a = 8'hFF; b = 8'h01; cin = 1'b0; end
          1:       begin op = 2'b01; a = 8'h80; b = 8'h01; cin = 1'b1; end
          2:       begin op = 2'b00; a = 8'h7F; b = 8'h01; cin = 1'b1; end
          default: begin
            op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom);
          end
        endcase
        exp_r[c] = model(op, a, b, cin);
        drive_sweep(1'b1, op, a, b, cin);
      end else begin
        drive_sweep(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      end
      #1;
      idx = c - 1;
      n_checks++;
      if (idx >= 0 && idx < N) begin
        if ({sw1.out_valid, sw1.zero, sw1.ovf, sw1.cout, sw1.sum} !== {1'b1, exp_r[idx]}) begin
          n_fail++;
          $display("FAIL ps1 beat %0d: got {v,z,o,c,sum}=%h, want %h", idx,
                   {sw1.out_valid, sw1.zero, sw1.ovf, sw1.cout, sw1.sum}, {1'b1, exp_r[idx]});
        end
      end else if (sw1.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ps1 idle cyc %0d: got out_valid=%b, want 0", c, sw1.out_valid);
      end
      idx = c - 3;
      n_checks++;
      if (idx >= 0 && idx < N) begin
        if ({sw3.out_valid, sw3.zero, sw3.ovf, sw3.cout, sw3.sum} !== {1'b1, exp_r[idx]}) begin
          n_fail++;
          $display("FAIL ps3 beat %0d: got {v,z,o,c,sum}=%h, want %h", idx,
                   {sw3.out_valid, sw3.zero, sw3.ovf, sw3.cout, sw3.sum}, {1'b1, exp_r[idx]});
        end
      end else if (sw3.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ps3 idle cyc %0d: got out_valid=%b, want 0", c, sw3.out_valid);
      end
      idx = c - 4;
      n_checks++;
      if (idx >= 0 && idx < N) begin
        if ({sw4.out_valid, sw4.zero, sw4.ovf, sw4.cout, sw4.sum} !== {1'b1, exp_r[idx]}) begin
          n_fail++;
          $display("FAIL ps4 beat %0d: got {v,z,o,c,sum}=%h, want %h", idx,
                   {sw4.out_valid, sw4.zero, sw4.ovf, sw4.cout, sw4.sum}, {1'b1, exp_r[idx]});
        end
      end else if (sw4.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ps4 idle cyc %0d: got out_valid=%b, want 0", c, sw4.out_valid);
      end
      tick();
    end
  endtask

`ifdef PPTREE_PIPE_ALU_SAT_EN
  task automatic test_sat();
    logic [1:0]  t_op  [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [7:0]  t_a   [4] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    logic        t_sat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    // {cout, ovf, zero, sum}
    logic [10:0] t_exp [4] = '{{1'b0, 1'b1, 1'b0, 8'h7F},
                              {1'b1, 1'b1, 1'b0, 8'h80},
                              {1'b0, 1'b1, 1'b0, 8'h80},
                              {1'b1, 1'b1, 1'b0, 8'h7F}};
    for (int i = 0; i < 4; i++) begin
      bus.sat = t_sat[i];
      run_op(t_op[i], t_a[i], 8'h01, 1'b0);
      n_checks++;
      if ({bus.cout, bus.ovf, bus.zero, bus.sum} !== t_exp[i] || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sat[%0d]: got valid=%b {c,o,z,sum}=%h, want 1 %h", i, bus.out_valid,
                 {bus.cout, bus.ovf, bus.zero, bus.sum}, t_exp[i]);
      end
    end
    bus.sat = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    sw1.out_ready = 1'b1; sw3.out_ready = 1'b1; sw4.out_ready = 1'b1;
    drive_sweep(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
`ifdef PPTREE_PIPE_ALU_SAT_EN
    bus.sat = 1'b0; sw1.sat = 1'b0; sw3.sat = 1'b0; sw4.sat = 1'b0;
`endif
    #1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_midflight();
    test_depth_sweep();
`ifdef PPTREE_PIPE_ALU_SAT_EN
    test_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pptree_pipe_alu.md
Name: pptree_pipe_alu

Overview:
- Parametrised, pipelined prefix-tree add/subtract unit. Next generation of the team's $alu techmap adder.
- Adds configurable width, configurable pipeline depth, an op-select, a valid/ready handshake with backpressure, and status flags.
- Sits between datapath operand registers and the writeback/flag logic. Instantiated directly, not via techmap.

Parameters:
- WIDTH, 32: operand/result width; >= 2; power of two not required.
- PIPE_STAGES, 2: register stages; 1..LEVELS+1, where LEVELS = clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- op  input  2  00 ADD (a+b+cin), 01 SUB (a-b, cin ignored), 10 SBC (a+~b+cin), 11 treated as ADD
- a  input  WIDTH  operand A, unsigned/two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry in; used by ADD and SBC only
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH-1; for SUB/SBC, 1 means no borrow
- ovf  output  1  signed overflow: c[WIDTH-1] ^ c[WIDTH-2]
- zero  output  1  sum == 0

Behaviour:
- Reset is asynchronous (rst_n low): all stage valid bits 0; out_valid=0; sum/cout/ovf/zero=0; in_ready=1 from the first cycle after release.
- Operand prep:
  - bb = b for ADD; ~b for SUB/SBC.
  - Effective carry-in: cin for ADD/SBC; 1 for SUB.
  - g = a & bb; p = a ^ bb.
  - Carry-in is folded into bit 0: g0' = g0 | (p0 & cin_eff).
- Prefix tree:
  - Kogge-Stone, LEVELS levels of (G,P) combine: G = Gh | (Ph & Gl), P = Ph & Pl.
  - sum = p ^ {C[WIDTH-2:0], cin_eff}; cout = C[WIDTH-1].
- Registers:
  - Register 1 sits after operand prep.
  - Register PIPE_STAGES is the output register.
  - Intermediate register k (1 < k < PIPE_STAGES) sits after level floor((k-1)*LEVELS/(PIPE_STAGES-1)).
  - When PIPE_STAGES=1, only the output register exists; prep and tree are combinational before it.
  - p and op-independent data travel alongside G/P in every stage.
- Latency: a beat accepted at edge t appears on the outputs with out_valid=1 after edge t+PIPE_STAGES-1. Results are in-order, one per cycle at full throughput.
- Handshake:
  - Global stall rule: advance = !out_valid | out_ready; in_ready = advance (combinational path from out_ready).
  - When advance=0, every stage holds, including data and valid bits.
  - Accept occurs when in_valid & in_ready.
  - Bubbles are not squeezed out.
- Outputs are held stable while out_valid & !out_ready.
- Simultaneous output drain and new accept in one cycle: both happen; no loss or duplication.
- in_valid low: a bubble (valid=0) enters; data registers may still load (don't care).
- Reset mid-flight: all in-flight beats are discarded, with no partial output.

Optional Feature:
- Macro: PPTREE_PIPE_ALU_SAT_EN.
- Defined:
  - Extra input port sat (1 bit), sampled with the operands and piped alongside.
  - When sat=1 and ovf=1, sum clamps to 0x7F..F if the true result is positive (a[msb]=0), else 0x80..0.
  - ovf still reports 1; zero is computed on the clamped value.
- Undefined: no sat port; results always wrap modulo 2^WIDTH.

Decomposition:
- Package pptree_pkg:
  - op enum (OP_ADD, OP_SUB, OP_SBC).
  - clog2-based LEVELS function.
  - Function stage_after_level(k, levels, stages) returning register placement.
  - Typedef of the gp_t pair.
- Sub-module pptree_level:
  - One combinational Kogge-Stone level, parametrised by WIDTH and span 2^level.
  - Generated LEVELS times, with optional register insertion between instances.

Test Plan (WIDTH=8, PIPE_STAGES=2 unless noted):
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0; after release, in_ready=1.
- ADD a=0xFF, b=0x01, cin=0 -> two edges later: sum=0x00, cout=1, zero=1, ovf=0.
- SUB a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1. SBC a=0x00, b=0x00, cin=0 -> sum=0xFF, cout=0.
- Backpressure: stream 5 ADDs (i+i for i=1..5), out_ready=0 for cycles 3-5 -> results 2,4,6,8,10 in order, none lost/duplicated; in_ready=0 during the stall.
- Reset mid-flight: assert rst_n=0 with 2 beats in the pipe -> no out_valid after release until new input. Repeat the sweep for PIPE_STAGES=1,3,4 and random a/b against a reference model.
- SAT_EN build: ADD 0x7F+0x01, sat=1 -> sum=0x7F, ovf=1. SUB 0x80-0x01, sat=1 -> sum=0x80. Same with sat=0 -> 0x80, 0x7F.
